// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: operand-B select, EX/MEM and MEM/WB forwarding,
// load-use bubble insertion and stall/flush handling for the pipelined MIPS core.
module alu_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm_ext,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [1:0]        b_sel,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              exmem_wr,
    input  logic              memwb_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_valid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              load_use
);

    localparam int HALF_W = DATA_W / 2;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwdSrc_t;

    typedef enum logic [1:0] {
        B_RT    = 2'b00,
        B_IMM   = 2'b01,
        B_SHAMT = 2'b10,
        B_UPPER = 2'b11
    } bSel_t;

    fwdSrc_t           fwdSelA;
    fwdSrc_t           fwdSelB;
    logic [DATA_W-1:0] fa;
    logic [DATA_W-1:0] fb;
    logic [DATA_W-1:0] opBNext;
    logic              usesRt;
    logic              loadUse;

    // The younger EX/MEM result shadows MEM/WB; r0 is hardwired and never forwarded.
    function automatic fwdSrc_t pickSource(
        input logic [REG_AW-1:0] src,
        input logic              exWr,
        input logic [REG_AW-1:0] exRd,
        input logic              wbWr,
        input logic [REG_AW-1:0] wbRd
    );
        if (src == '0)
            return FWD_NONE;
        else if (exWr && (exRd == src))
            return FWD_EXMEM;
        else if (wbWr && (wbRd == src))
            return FWD_MEMWB;
        else
            return FWD_NONE;
    endfunction

    always_comb begin
        fwdSelA = pickSource(rs_addr, exmem_wr, exmem_rd, memwb_wr, memwb_rd);
        fwdSelB = pickSource(rt_addr, exmem_wr, exmem_rd, memwb_wr, memwb_rd);
    end

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        fa = rs_data;
        case (fwdSelA)
            FWD_EXMEM: fa = exmem_data;
            FWD_MEMWB: fa = memwb_data;
            default:   fa = rs_data;
        endcase
    end

    always_comb begin
        fb = rt_data;
        case (fwdSelB)
            FWD_EXMEM: fb = exmem_data;
            FWD_MEMWB: fb = memwb_data;
            default:   fb = rt_data;
        endcase
    end

    always_comb begin
        opBNext = fb;
        case (bSel_t'(b_sel))
            B_IMM:   opBNext = imm_ext;
            B_SHAMT: opBNext = {{(DATA_W-SHAMT_W){1'b0}}, shamt};
            B_UPPER: opBNext = {imm_ext[HALF_W-1:0], {HALF_W{1'b0}}};
            default: opBNext = fb;
        endcase
    end

    // Stores read rt even with an immediate operand B, so they can hazard on rt too.
    assign usesRt  = (b_sel == B_RT) | in_mem_write;
    assign loadUse = out_valid & out_mem_read & (out_rd != '0) & in_valid
                   & ((rs_addr == out_rd) | (usesRt & (rt_addr == out_rd)));
    assign load_use = loadUse;

    // NOTE: sequential state uses non-blocking assignments only; every output flop is reset
    // because downstream stages treat a zero out_valid/fwd as the idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a          <= '0;
            op_b          <= '0;
            store_data    <= '0;
            out_rd        <= '0;
            out_mem_read  <= 1'b0;
            out_mem_write <= 1'b0;
            out_valid     <= 1'b0;
            fwd_a         <= FWD_NONE;
            fwd_b         <= FWD_NONE;
        end else if (flush) begin
            op_a          <= '0;
            op_b          <= '0;
            store_data    <= '0;
            out_rd        <= '0;
            out_mem_read  <= 1'b0;
            out_mem_write <= 1'b0;
            out_valid     <= 1'b0;
            fwd_a         <= FWD_NONE;
            fwd_b         <= FWD_NONE;
        end else if (!stall) begin
            if (loadUse) begin
                // Bubble: kill the control bits, leave the data path untouched.
                out_mem_read  <= 1'b0;
                out_mem_write <= 1'b0;
                out_valid     <= 1'b0;
                fwd_a         <= FWD_NONE;
                fwd_b         <= FWD_NONE;
            end else begin
                op_a          <= fa;
                op_b          <= opBNext;
                store_data    <= fb;
                out_rd        <= in_rd;
                out_mem_read  <= in_valid & in_mem_read;
                out_mem_write <= in_valid & in_mem_write;
                out_valid     <= in_valid;
                fwd_a         <= fwdSelA;
                fwd_b         <= fwdSelB;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: vector table for operand/forwarding modes,
// plus hand-built load-use, stall, flush and reset sequences, all through a scoreboard queue.
module tb_alu_operand_stage;

    localparam int DW = 32;
    localparam int SW = 5;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, flush, in_valid;
    logic [DW-1:0] rs_data, rt_data, imm_ext;
    logic [SW-1:0] shamt;
    logic [AW-1:0] rs_addr, rt_addr, in_rd;
    logic [1:0]    b_sel;
    logic          in_mem_read, in_mem_write;
    logic          exmem_wr, memwb_wr;
    logic [AW-1:0] exmem_rd, memwb_rd;
    logic [DW-1:0] exmem_data, memwb_data;
    logic [DW-1:0] op_a, op_b, store_data;
    logic [AW-1:0] out_rd;
    logic          out_mem_read, out_mem_write, out_valid;
    logic [1:0]    fwd_a, fwd_b;
    logic          load_use;

    alu_operand_stage #(.DATA_W(DW), .SHAMT_W(SW), .REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext), .shamt(shamt),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .in_rd(in_rd), .b_sel(b_sel),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .exmem_wr(exmem_wr), .memwb_wr(memwb_wr), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_data(exmem_data), .memwb_data(memwb_data),
        .op_a(op_a), .op_b(op_b), .store_data(store_data), .out_rd(out_rd),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_valid(out_valid),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use(load_use)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] opA;
        logic [DW-1:0] opB;
        logic [DW-1:0] storeData;
        logic [AW-1:0] rd;
        logic          memRead;
        logic          memWrite;
        logic          valid;
        logic [1:0]    fwdA;
        logic [1:0]    fwdB;
    } outs_t;

    typedef struct packed {
        logic          stall;
        logic          flush;
        logic          inValid;
        logic [DW-1:0] rsData;
        logic [DW-1:0] rtData;
        logic [DW-1:0] immExt;
        logic [SW-1:0] shamt;
        logic [AW-1:0] rsAddr;
        logic [AW-1:0] rtAddr;
        logic [AW-1:0] inRd;
        logic [1:0]    bSel;
        logic          memRead;
        logic          memWrite;
        logic          exWr;
        logic          wbWr;
        logic [AW-1:0] exRd;
        logic [AW-1:0] wbRd;
        logic [DW-1:0] exData;
        logic [DW-1:0] wbData;
        logic          expLoadUse;
        outs_t         expOut;
    } vec_t;

    outs_t sbQ[$];
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOuts(input string tag, input outs_t e);
        check({tag, ".op_a"},          op_a,          e.opA);
        check({tag, ".op_b"},          op_b,          e.opB);
        check({tag, ".store_data"},    store_data,    e.storeData);
        check({tag, ".out_rd"},        out_rd,        e.rd);
        check({tag, ".out_mem_read"},  out_mem_read,  e.memRead);
        check({tag, ".out_mem_write"}, out_mem_write, e.memWrite);
        check({tag, ".out_valid"},     out_valid,     e.valid);
        check({tag, ".fwd_a"},         fwd_a,         e.fwdA);
        check({tag, ".fwd_b"},         fwd_b,         e.fwdB);
    endtask

    function automatic outs_t mkOut(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [DW-1:0] st, input logic [AW-1:0] rd,
                                    input logic mr, input logic mw, input logic vld,
                                    input logic [1:0] fa, input logic [1:0] fb);
        outs_t o;
        o.opA = a; o.opB = b; o.storeData = st; o.rd = rd;
        o.memRead = mr; o.memWrite = mw; o.valid = vld; o.fwdA = fa; o.fwdB = fb;
        return o;
    endfunction

    task automatic drive(input vec_t v);
        stall = v.stall; flush = v.flush; in_valid = v.inValid;
        rs_data = v.rsData; rt_data = v.rtData; imm_ext = v.immExt; shamt = v.shamt;
        rs_addr = v.rsAddr; rt_addr = v.rtAddr; in_rd = v.inRd; b_sel = v.bSel;
        in_mem_read = v.memRead; in_mem_write = v.memWrite;
        exmem_wr = v.exWr; memwb_wr = v.wbWr; exmem_rd = v.exRd; memwb_rd = v.wbRd;
        exmem_data = v.exData; memwb_data = v.wbData;
    endtask

    // Drive at the falling edge, check the combinational hazard flag, queue the expected
    // registered outputs, then compare them just after the next rising edge.
    task automatic applyVec(input string tag, input vec_t v);
        outs_t e;
        @(negedge clk);
        drive(v);
        #1;
        check({tag, ".load_use"}, load_use, v.expLoadUse);
        sbQ.push_back(v.expOut);
        @(posedge clk);
        #1;
        if (sbQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s.scoreboard: got empty queue, expected one entry", tag);
        end else begin
            e = sbQ.pop_front();
            checkOuts(tag, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        vec_t  v;
        vec_t  tbl[$];
        vec_t  hz;
        outs_t held;

        // Reset with random inputs: every registered output must be zero.
        rst_n = 1'b0;
        v = '0;
        v.stall = 1'($urandom); v.flush = 1'($urandom); v.inValid = 1'b1;
        v.rsData = $urandom; v.rtData = $urandom; v.immExt = $urandom;
        v.shamt = SW'($urandom); v.rsAddr = AW'($urandom); v.rtAddr = AW'($urandom);
        v.inRd = AW'($urandom); v.bSel = 2'($urandom); v.memRead = 1'b1; v.memWrite = 1'b1;
        v.exWr = 1'b1; v.wbWr = 1'b1; v.exRd = AW'($urandom); v.wbRd = AW'($urandom);
        v.exData = $urandom; v.wbData = $urandom;
        drive(v);
        #1;
        checkOuts("reset", '0);
        check("reset.load_use", load_use, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOuts("reset_held", '0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        v = '0; v.inValid = 1; v.bSel = 2'b01; v.immExt = 32'hFFFF_FFF0;
        v.rsAddr = 1; v.rsData = 32'h11; v.rtAddr = 2; v.rtData = 32'h22; v.inRd = 4;
        v.expOut = mkOut(32'h11, 32'hFFFF_FFF0, 32'h22, 4, 0, 0, 1, 2'b00, 2'b00);
        tbl.push_back(v);

        v = '0; v.inValid = 1; v.bSel = 2'b00; v.rsAddr = 3; v.rsData = 32'h1;
        v.rtAddr = 6; v.rtData = 32'h66; v.inRd = 7;
        v.exWr = 1; v.exRd = 3; v.exData = 32'hAAAA; v.wbWr = 1; v.wbRd = 3; v.wbData = 32'hBBBB;
        v.expOut = mkOut(32'hAAAA, 32'h66, 32'h66, 7, 0, 0, 1, 2'b10, 2'b00);
        tbl.push_back(v);

        v.exWr = 0; v.rtAddr = 3;
        v.expOut = mkOut(32'hBBBB, 32'hBBBB, 32'hBBBB, 7, 0, 0, 1, 2'b01, 2'b01);
        tbl.push_back(v);

        v = '0; v.inValid = 1; v.bSel = 2'b10; v.shamt = 5'h1F; v.inRd = 8;
        v.exWr = 1; v.exRd = 0; v.exData = 32'hDEAD; v.wbWr = 1; v.wbRd = 0; v.wbData = 32'hBEEF;
        v.expOut = mkOut(32'h0, 32'h0000_001F, 32'h0, 8, 0, 0, 1, 2'b00, 2'b00);
        tbl.push_back(v);

        v = '0; v.inValid = 1; v.bSel = 2'b11; v.immExt = 32'hABCD_1234;
        v.rsAddr = 9; v.rsData = 32'h99; v.rtAddr = 10; v.rtData = 32'hA0; v.inRd = 11;
        v.expOut = mkOut(32'h99, 32'h1234_0000, 32'hA0, 11, 0, 0, 1, 2'b00, 2'b00);
        tbl.push_back(v);

        v = '0; v.inValid = 1; v.bSel = 2'b01; v.memWrite = 1; v.immExt = 32'h10;
        v.rsAddr = 13; v.rsData = 32'h130; v.rtAddr = 12; v.rtData = 32'h99;
        v.exWr = 1; v.exRd = 12; v.exData = 32'h55;
        v.expOut = mkOut(32'h130, 32'h10, 32'h55, 0, 0, 1, 1, 2'b00, 2'b10);
        tbl.push_back(v);

        v = '0; v.inValid = 0; v.bSel = 2'b00; v.memRead = 1; v.memWrite = 1;
        v.rsAddr = 1; v.rsData = 32'h5; v.rtAddr = 2; v.rtData = 32'h6; v.inRd = 3;
        v.expOut = mkOut(32'h5, 32'h6, 32'h6, 3, 0, 0, 0, 2'b00, 2'b00);
        tbl.push_back(v);

        for (int i = 0; i < tbl.size(); i++)
            applyVec($sformatf("tbl%0d", i), tbl[i]);

        // ---------------- load-use bubble ----------------
        v = '0; v.inValid = 1; v.memRead = 1; v.bSel = 2'b01; v.rsAddr = 1; v.rsData = 32'h100;
        v.immExt = 32'h4; v.rtAddr = 5; v.rtData = 32'h0; v.inRd = 5;
        v.expOut = mkOut(32'h100, 32'h4, 32'h0, 5, 1, 0, 1, 2'b00, 2'b00);
        applyVec("lu_load", v);

        v = '0; v.inValid = 1; v.bSel = 2'b00; v.rsAddr = 5; v.rsData = 32'h0;
        v.rtAddr = 6; v.rtData = 32'h66; v.inRd = 7; v.expLoadUse = 1;
        v.expOut = mkOut(32'h100, 32'h4, 32'h0, 5, 0, 0, 0, 2'b00, 2'b00);
        applyVec("lu_bubble", v);

        v.exWr = 1; v.exRd = 5; v.exData = 32'h77; v.expLoadUse = 0;
        v.expOut = mkOut(32'h77, 32'h66, 32'h66, 7, 0, 0, 1, 2'b10, 2'b00);
        applyVec("lu_forward", v);

        v = '0; v.inValid = 1; v.memRead = 1; v.bSel = 2'b01; v.rsAddr = 1; v.rsData = 32'h200;
        v.immExt = 32'h8; v.rtAddr = 5; v.rtData = 32'h3; v.inRd = 5;
        v.expOut = mkOut(32'h200, 32'h8, 32'h3, 5, 1, 0, 1, 2'b00, 2'b00);
        applyVec("nh_load", v);

        v = '0; v.inValid = 1; v.bSel = 2'b01; v.rsAddr = 2; v.rsData = 32'h20;
        v.immExt = 32'hC; v.rtAddr = 5; v.rtData = 32'h44; v.inRd = 9;
        v.expOut = mkOut(32'h20, 32'hC, 32'h44, 9, 0, 0, 1, 2'b00, 2'b00);
        applyVec("nh_imm", v);

        // ---------------- stall freezes outputs ----------------
        v = '0; v.inValid = 1; v.bSel = 2'b00; v.memWrite = 1; v.rsAddr = 1; v.rsData = 32'h1111;
        v.rtAddr = 2; v.rtData = 32'h2222; v.inRd = 3; v.wbWr = 1; v.wbRd = 2; v.wbData = 32'h3333;
        held = mkOut(32'h1111, 32'h3333, 32'h3333, 3, 0, 1, 1, 2'b00, 2'b01);
        v.expOut = held;
        applyVec("st_load", v);

        for (int i = 0; i < 3; i++) begin
            v = '0; v.stall = 1; v.inValid = 1; v.bSel = 2'b01; v.rsAddr = 4;
            v.rsData = 32'hFFFF_FFF0 + i; v.immExt = 32'h1234; v.inRd = 6;
            v.exWr = 1; v.exRd = 4; v.exData = 32'hDD;
            v.expOut = held;
            applyVec($sformatf("st_hold%0d", i), v);
        end

        // ---------------- stall during load-use ----------------
        v = '0; v.inValid = 1; v.memRead = 1; v.bSel = 2'b01; v.rsAddr = 1; v.rsData = 32'h500;
        v.immExt = 32'h10; v.rtAddr = 5; v.rtData = 32'h7; v.inRd = 5;
        held = mkOut(32'h500, 32'h10, 32'h7, 5, 1, 0, 1, 2'b00, 2'b00);
        v.expOut = held;
        applyVec("sl_load", v);

        v = '0; v.stall = 1; v.inValid = 1; v.bSel = 2'b00; v.rsAddr = 8; v.rsData = 32'h8;
        v.rtAddr = 5; v.rtData = 32'h9; v.inRd = 10; v.expLoadUse = 1;
        v.expOut = held;
        applyVec("sl_stall", v);

        v.stall = 0;
        v.expOut = mkOut(32'h500, 32'h10, 32'h7, 5, 0, 0, 0, 2'b00, 2'b00);
        applyVec("sl_bubble", v);

        v.wbWr = 1; v.wbRd = 5; v.wbData = 32'hCAFE; v.expLoadUse = 0;
        v.expOut = mkOut(32'h8, 32'hCAFE, 32'hCAFE, 10, 0, 0, 1, 2'b00, 2'b01);
        applyVec("sl_forward", v);

        // ---------------- flush ----------------
        v = '0; v.stall = 1; v.flush = 1; v.inValid = 1; v.memRead = 1; v.bSel = 2'b01;
        v.rsAddr = 3; v.rsData = 32'h1234; v.immExt = 32'h55; v.inRd = 3;
        v.expOut = '0;
        applyVec("fl_stall", v);

        v = '0; v.inValid = 1; v.memRead = 1; v.bSel = 2'b01; v.rsAddr = 1; v.rsData = 32'h600;
        v.immExt = 32'h20; v.rtAddr = 0; v.inRd = 5;
        v.expOut = mkOut(32'h600, 32'h20, 32'h0, 5, 1, 0, 1, 2'b00, 2'b00);
        applyVec("fl_load", v);

        hz = '0; hz.inValid = 1; hz.bSel = 2'b01; hz.rsAddr = 5; hz.rsData = 32'h4242;
        hz.immExt = 32'h3; hz.rtAddr = 2; hz.rtData = 32'h2; hz.inRd = 12;
        v = hz; v.flush = 1; v.expLoadUse = 1; v.expOut = '0;
        applyVec("fl_hazard", v);

        v = hz; v.expLoadUse = 0;
        v.expOut = mkOut(32'h4242, 32'h3, 32'h2, 12, 0, 0, 1, 2'b00, 2'b00);
        applyVec("fl_after", v);

        // ---------------- asynchronous reset during a pending hazard ----------------
        v = '0; v.inValid = 1; v.memRead = 1; v.bSel = 2'b01; v.rsAddr = 1; v.rsData = 32'h700;
        v.immExt = 32'h30; v.inRd = 5;
        v.expOut = mkOut(32'h700, 32'h30, 32'h0, 5, 1, 0, 1, 2'b00, 2'b00);
        applyVec("rs_load", v);

        @(negedge clk);
        drive(hz);
        #1;
        check("rs_pending.load_use", load_use, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOuts("rs_async", '0);
        check("rs_async.load_use", load_use, 1'b0);
        @(posedge clk);
        #1;
        checkOuts("rs_held", '0);
        @(negedge clk);
        rst_n = 1'b1;

        v = hz; v.expLoadUse = 0;
        v.expOut = mkOut(32'h4242, 32'h3, 32'h2, 12, 0, 0, 1, 2'b00, 2'b00);
        applyVec("rs_release", v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised ID/EX operand stage for the pipelined MIPS core. It replaces the combinational ALU operand-B select with a registered stage that does four things: selects operand B (register, sign-extended immediate, shift amount, upper immediate), forwards results from EX/MEM and MEM/WB, detects load-use hazards and inserts bubbles, and honours stall/flush. It sits between register-file read (ID) and the ALU (EX).

## Interface
- DATA_W, 32, datapath width; must be even and ≥ 2*SHAMT_W
- SHAMT_W, 5, shift-amount field width
- REG_AW, 5, register address width
---
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all output registers
- flush  in  1  kill the instruction being captured
- in_valid  in  1  ID holds a valid instruction
- rs_data, rt_data  in  DATA_W  register-file read data
- imm_ext  in  DATA_W  sign-extended immediate
- shamt  in  SHAMT_W  shift amount
- rs_addr, rt_addr, in_rd  in  REG_AW  source/destination register numbers
- b_sel  in  2  operand-B mode: 00 rt, 01 imm_ext, 10 shamt, 11 upper immediate
- in_mem_read, in_mem_write  in  1  instruction is a load / store
- exmem_wr, memwb_wr  in  1  later stage will write the register file
- exmem_rd, memwb_rd  in  REG_AW  later-stage destination registers
- exmem_data, memwb_data  in  DATA_W  later-stage results
- op_a, op_b  out  DATA_W  registered ALU operands
- store_data  out  DATA_W  registered forwarded rt value
- out_rd  out  REG_AW  registered destination register
- out_mem_read, out_mem_write, out_valid  out  1  registered control bits
- fwd_a, fwd_b  out  2  registered forward source: 00 none, 01 MEM/WB, 10 EX/MEM
- load_use  out  1  combinational hazard flag; upstream holds ID while high

## Operation
- Forwarding, per source register (rs, rt), evaluated independently:
  - EX/MEM wins when exmem_wr is high, exmem_rd equals the source, and the source is not 0.
  - Otherwise MEM/WB wins under the same conditions on memwb_wr/memwb_rd.
  - Otherwise the register-file data is used.
  - Register 0 is never forwarded.
- fa / fb: the forwarded rs / rt values.
- op_a = fa.
- op_b by b_sel:
  - 00 → fb
  - 01 → imm_ext
  - 10 → shamt zero-extended to DATA_W
  - 11 → imm_ext[DATA_W/2-1:0] in the upper half, lower half zero
- store_data = fb in all modes.
- uses_rt = (b_sel==00) | in_mem_write.
- load_use = out_valid & out_mem_read & (out_rd≠0) & in_valid & ((rs_addr==out_rd) | (uses_rt & rt_addr==out_rd)).
- Register update priority, per clock edge:
  1. flush: all outputs go to zero and out_valid=0. Flush overrides stall.
  2. stall: all output registers hold.
  3. load_use: inject a bubble. out_valid, out_mem_read and out_mem_write go to 0; data registers hold; fwd_a = fwd_b = 00.
  4. Otherwise capture:
     - out_valid = in_valid.
     - If in_valid=0, the control bits (mem_read, mem_write) are 0 and data is don't-care but still registered.
- Once the bubble is in place, load_use deasserts. On the next edge the load result comes from EX/MEM or MEM/WB through normal forwarding.

## Timing
- Reset (rst_n low, asynchronous): every registered output is 0, including out_valid, fwd_a and fwd_b.
- Release on the first rising edge with rst_n high.
- Latency: 1 cycle from inputs to registered outputs. Forward selection uses same-cycle exmem/memwb inputs.
- load_use is combinational from the inputs and the current registered state. It is valid in the same cycle and asserts for exactly one cycle per load-use pair unless stall is held.
- Simultaneous stall and load_use: stall wins and load_use stays asserted.
- Reset mid-stall or mid-bubble: everything clears. No hazard is pending after release.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0. Release, then in_valid=1, b_sel=01, imm_ext=0xFFFF_FFF0 → next cycle op_b=0xFFFF_FFF0, out_valid=1.
- Forward priority: rs_addr=3 with exmem_rd=3 (data 0xAAAA) and memwb_rd=3 (data 0xBBBB), both wr=1 → op_a=0xAAAA, fwd_a=10. With exmem_wr=0 → op_a=0xBBBB, fwd_a=01.
- Register zero: rs_addr=0, exmem_rd=0, exmem_wr=1, rs_data=0 → op_a=0, fwd_a=00.
- Modes:
  - b_sel=10, shamt=0x1F → op_b=0x0000_001F.
  - b_sel=11, imm_ext=0x0000_1234 → op_b=0x1234_0000.
  - b_sel=01 with store, rt forwarded 0x55 → store_data=0x55.
- Load-use: load to r5 captured, then next instruction has rs_addr=5 → load_use=1 for one cycle and a bubble (out_valid=0). Following cycle with exmem_rd=5, data 0x77 → op_a=0x77. With b_sel=01 and rt_addr=5 (non-store) → no hazard.
- Stall/flush: stall=1 for 3 cycles → outputs frozen. stall=1 with flush=1 → out_valid=0, all outputs 0.
